// File: rtl/dti_pkg.sv
// Shared definitions for the dti valid/ready channel blocks.
package dti_pkg;

    localparam int DTI_W_DATA_DEFAULT = 64;
    localparam int DTI_DEPTH_DEFAULT  = 2;

    // Index width for a DEPTH-entry buffer; never returns 0, so degenerate sizes still elaborate.
    function automatic int clog2_safe(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dti_if.sv
// dti valid/ready channel: producer drives data/valid, consumer drives ready.
interface dti_if #(
    parameter int W_DATA = dti_pkg::DTI_W_DATA_DEFAULT
);
    logic [W_DATA-1:0] data;
    logic              valid;
    logic              ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/dti_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module dti_fifo_mem
    import dti_pkg::*;
#(
    parameter int W_DATA = DTI_W_DATA_DEFAULT,
    parameter int DEPTH  = DTI_DEPTH_DEFAULT,
    localparam int AW    = clog2_safe(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [W_DATA-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [W_DATA-1:0] o_rdata
);

    logic [W_DATA-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dti_decouple.sv
// Elastic decoupling stage: DEPTH-entry circular FIFO between two dti channels.
// All handshake outputs come from registered pointers, so no path crosses din<->dout.
module dti_decouple
    import dti_pkg::*;
#(
    parameter int W_DATA = DTI_W_DATA_DEFAULT,
    parameter int DEPTH  = DTI_DEPTH_DEFAULT
) (
    input logic     clk,
    input logic     rst_n,
    dti_if.consumer din,
    dti_if.producer dout
);

    localparam int AW = clog2_safe(DEPTH);
    typedef logic [AW:0] ptr_t;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("dti_decouple: DEPTH must be a power of two and >= 2");
    end

    ptr_t              r_wr_ptr;
    ptr_t              r_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [W_DATA-1:0] w_rdata;

    // Extra MSB acts as a wrap flag: same index with differing wrap bit means full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign din.ready  = !w_full && rst_n;
    assign dout.valid = !w_empty;
    assign dout.data  = w_rdata;

    assign w_push = din.valid && din.ready;
    assign w_pop  = dout.valid && dout.ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
        end
    end

    dti_fifo_mem #(
        .W_DATA (W_DATA),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (din.data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_dti_decouple.sv
// Bench for dti_decouple: DEPTH=2 and DEPTH=4 instances checked every cycle against queue models.
module tb_dti_decouple;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dti_if #(.W_DATA(64)) in2 ();
    dti_if #(.W_DATA(64)) out2 ();
    dti_if #(.W_DATA(64)) in4 ();
    dti_if #(.W_DATA(64)) out4 ();

    dti_decouple #(.W_DATA(64), .DEPTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in2),
        .dout  (out2)
    );

    dti_decouple #(.W_DATA(64), .DEPTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in4),
        .dout  (out4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a plain bounded queue per instance, words in order of acceptance.
    logic [63:0] q2[$];
    logic [63:0] q4[$];
    logic [63:0] log2[$];
    logic [63:0] log4[$];
    bit          mon_en = 0;
    bit          strm_en = 0;
    bit          stall_en = 0;
    int          strm_drops = 0;
    int          acc4 = 0;
    bit          hold_v = 0;
    logic [63:0] hold_d;
    bit          p2, o2, p4, o4;

    always @(posedge clk) begin
        if (!rst_n) begin
            q2.delete();
            q4.delete();
        end else begin
            p2 = in2.valid && (q2.size() < 2);
            o2 = out2.ready && (q2.size() > 0);
            p4 = in4.valid && (q4.size() < 4);
            o4 = out4.ready && (q4.size() > 0);
            if (o2) void'(q2.pop_front());
            if (p2) q2.push_back(in2.data);
            if (o4) void'(q4.pop_front());
            if (p4) q4.push_back(in4.data);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("d2_ready", in2.ready, rst_n && (q2.size() < 2));
            chk("d2_valid", out2.valid, q2.size() > 0);
            if (q2.size() > 0) chk("d2_data", out2.data, q2[0]);
            chk("d4_ready", in4.ready, rst_n && (q4.size() < 4));
            chk("d4_valid", out4.valid, q4.size() > 0);
            if (q4.size() > 0) chk("d4_data", out4.data, q4[0]);
            if (out2.valid && out2.ready) log2.push_back(out2.data);
            if (out4.valid && out4.ready) log4.push_back(out4.data);
            if (in4.valid && in4.ready) acc4++;
            if (strm_en && !in2.ready) strm_drops++;
            if (stall_en) begin
                if (hold_v) chk("stall_hold", out4.data, hold_d);
                hold_v = out4.valid && !out4.ready;
                hold_d = out4.data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nxt;
        int bad;
        int cyc;
        bit acc;

        in2.valid = 1'b1; in2.data = 64'hDEAD; out2.ready = 1'b1;
        in4.valid = 1'b1; in4.data = 64'hBEEF; out4.ready = 1'b1;

        // Reset held 3 cycles with valid asserted: nothing may be accepted.
        rst_n = 1'b0;
        step();
        mon_en = 1;
        step();
        step();
        rst_n = 1'b1;
        in2.valid = 1'b0;
        in4.valid = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready2", in2.ready, 1);
        chk("rst_rel_valid2", out2.valid, 0);
        chk("rst_rel_ready4", in4.ready, 1);
        chk("rst_rel_valid4", out4.valid, 0);
        step();
        step();
        chk("rst_no_accept", log2.size() + log4.size(), 0);

        // Streaming through DEPTH=2 at full rate.
        strm_en = 1;
        out2.ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in2.valid = 1'b1;
            in2.data  = 64'(i);
            step();
        end
        in2.valid = 1'b0;
        repeat (3) step();
        strm_en = 0;
        chk("strm_ready_drops", strm_drops, 0);
        chk("strm_count", log2.size(), 16);
        bad = 0;
        for (int i = 0; i < log2.size(); i++) if (log2[i] !== 64'(i + 1)) bad++;
        chk("strm_order", bad, 0);

        // Fill DEPTH=4 under backpressure, then drain.
        log4.delete();
        acc4 = 0;
        out4.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in4.valid = 1'b1;
            in4.data  = 64'hA0 + 64'(i);
            step();
        end
        in4.data = 64'hA4;
        step();
        @(negedge clk);
        chk("fill_ready", in4.ready, 0);
        chk("fill_head", out4.data, 64'hA0);
        chk("fill_acc", acc4, 4);
        step();
        out4.ready = 1'b1;
        step();
        @(negedge clk);
        chk("recover_ready", in4.ready, 1);
        step();
        in4.data = 64'hA5;
        step();
        in4.valid = 1'b0;
        repeat (6) step();
        chk("drain_count", log4.size(), 6);
        bad = 0;
        for (int i = 0; i < log4.size(); i++) if (log4[i] !== 64'hA0 + 64'(i)) bad++;
        chk("drain_order", bad, 0);

        // Random valid/ready, 1000 incrementing words through DEPTH=4.
        log4.delete();
        nxt = 0;
        cyc = 0;
        while (log4.size() < 1000 && cyc < 20000) begin
            in4.valid  = (nxt < 1000) && ($urandom_range(0, 1) == 1);
            in4.data   = 64'(nxt);
            out4.ready = ($urandom_range(0, 1) == 1);
            acc = in4.valid && (q4.size() < 4);
            step();
            if (acc) nxt++;
            cyc++;
        end
        in4.valid = 1'b0;
        out4.ready = 1'b1;
        repeat (6) step();
        chk("wrap_count", log4.size(), 1000);
        bad = 0;
        for (int i = 0; i < log4.size(); i++) if (log4[i] !== 64'(i)) bad++;
        chk("wrap_order", bad, 0);
        chk("wrap_ge100", (log4.size() / 4) >= 100, 1);

        // Mid-stream reset with 3 words buffered.
        log4.delete();
        out4.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in4.valid = 1'b1;
            in4.data  = 64'h100 + 64'(i);
            step();
        end
        in4.valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_valid", out4.valid, 0);
        in4.valid = 1'b1;
        in4.data  = 64'h55;
        step();
        in4.valid = 1'b0;
        out4.ready = 1'b1;
        repeat (3) step();
        chk("mrst_count", log4.size(), 1);
        chk("mrst_first", (log4.size() > 0) ? log4[0] : 64'hFFFF_FFFF_FFFF_FFFF, 64'h55);

        // Saturated input with dout.ready toggling every cycle.
        log4.delete();
        nxt = 0;
        stall_en = 1;
        for (int c = 0; c < 200; c++) begin
            in4.valid  = 1'b1;
            in4.data   = 64'h1000 + 64'(nxt);
            out4.ready = c[0];
            acc = q4.size() < 4;
            step();
            if (acc) nxt++;
        end
        in4.valid = 1'b0;
        out4.ready = 1'b1;
        repeat (6) step();
        stall_en = 0;
        chk("stall_count", log4.size(), nxt);
        bad = 0;
        for (int i = 0; i < log4.size(); i++) if (log4[i] !== 64'h1000 + 64'(i)) bad++;
        chk("stall_order", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
